// File: rtl/debug_uart_tx_sched_if.sv
// Write-side bus of the debug UART transmit scheduler: core write strobe,
// flush, and the status readback (level/full/overflow/busy).
interface debug_uart_tx_sched_if #(
  parameter int DEPTH_LOG2 = 3
) ();
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  flush;
  logic [DEPTH_LOG2:0]   level;
  logic                  full;
  logic                  overflow;
  logic                  busy;

  modport master (
    output wr_en, wr_data, flush,
    input  level, full, overflow, busy
  );

  modport slave (
    input  wr_en, wr_data, flush,
    output level, full, overflow, busy
  );
endinterface

// File: rtl/debug_uart_tx_sched.sv
// Debug UART transmit scheduler: queues bytes in a small FIFO and launches
// each one exactly once into uart_tx, sequencing uart_tx_en against
// uart_tx_busy.
// Optional build macro DEBUG_UART_TX_BLOCKING_EN: adds the stall output and
// holds full writes instead of dropping them (overflow then never sets).
//
// state      | meaning
// IDLE       | waiting for a queued byte and uart_tx idle
// LAUNCH     | uart_tx_en pulse for the byte just popped
// WAIT_START | waiting for uart_tx_busy to rise, bounded by START_TIMEOUT
// WAIT_DONE  | byte in flight, waiting for uart_tx_busy to fall
module debug_uart_tx_sched #(
  parameter int DEPTH_LOG2    = 3,
  parameter int START_TIMEOUT = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  debug_uart_tx_sched_if.slave        bus,
  input  logic                        uart_tx_busy,
  output logic                        uart_tx_en,
  output logic [7:0]                  uart_tx_data
`ifdef DEBUG_UART_TX_BLOCKING_EN
  ,
  output logic                        stall
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  overflow_q;
  logic [7:0]            data_q;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  overflow_set;

  assign full = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
  // A pop in the same cycle frees a slot, so a write into a full FIFO can still land.
  assign push = bus.wr_en && !bus.flush && (!full || pop);

`ifdef DEBUG_UART_TX_BLOCKING_EN
  assign stall        = bus.wr_en && full && !pop;
  assign overflow_set = 1'b0;
`else
  assign overflow_set = bus.wr_en && !bus.flush && full && !pop;
`endif

  // FSM state and start-timeout down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state, pop decision and launch pulse.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    uart_tx_en = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush in the same cycle wins: nothing is launched from a FIFO being cleared.
        if (level_q != '0 && !uart_tx_busy && !bus.flush) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        uart_tx_en = 1'b1;
        tmo_d      = TW'(START_TIMEOUT - 1);
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == '0) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Pointers, occupancy, sticky overflow and the launched-byte register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
    end else begin
      if (pop) begin
        data_q <= mem[rd_ptr_q];
      end
      if (bus.flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        level_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
        if (overflow_set) overflow_q <= 1'b1;
      end
    end
  end

  assign uart_tx_data = data_q;
  assign bus.level    = level_q;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (level_q != '0) || (state_q != IDLE) || uart_tx_busy;

endmodule

// File: tb/tb_debug_uart_tx_sched.sv
// Directed bench for debug_uart_tx_sched (default, non-blocking build) with a
// small uart_tx model that holds busy for a programmable number of cycles.
module tb_debug_uart_tx_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_uart_tx_sched_if #(.DEPTH_LOG2(3)) bus ();

  logic       uart_tx_busy;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
`ifdef DEBUG_UART_TX_BLOCKING_EN
  logic       stall;
`endif

  debug_uart_tx_sched #(.DEPTH_LOG2(3), .START_TIMEOUT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data)
`ifdef DEBUG_UART_TX_BLOCKING_EN
    ,
    .stall        (stall)
`endif
  );

  int         hold = 5;
  bit         never_busy = 1'b0;
  int         m_cnt;
  logic [7:0] tx_log [64];
  int         n_tx = 0;
  int         vectors = 0;
  int         errors = 0;
  int         base;

  // uart_tx model: busy rises the edge after a launch and lasts 'hold' cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx_busy <= 1'b0;
      m_cnt        <= 0;
    end else if (uart_tx_en && !never_busy) begin
      uart_tx_busy <= 1'b1;
      m_cnt        <= hold;
    end else if (uart_tx_busy) begin
      if (m_cnt == 1) uart_tx_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end
  end

  // Log of every launched byte.
  always @(posedge clk) begin
    if (uart_tx_en) begin
      tx_log[n_tx[5:0]] <= uart_tx_data;
      n_tx <= n_tx + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (bus.busy !== 1'b0 && k < max) begin
      cyc();
      k++;
    end
    chk("idle_reached", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush   = 1'b0;

    // Reset values
    #12;
    chk("rst_level",    {28'd0, bus.level},  32'd0);
    chk("rst_full",     {31'd0, bus.full},   32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst_busy",     {31'd0, bus.busy},   32'd0);
    chk("rst_en",       {31'd0, uart_tx_en}, 32'd0);
    chk("rst_data",     {24'd0, uart_tx_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    cyc();

    // Single byte: launch two cycles after the write
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    cyc();
    bus.wr_en = 1'b0;
    chk("single_level_n1", {28'd0, bus.level}, 32'd1);
    chk("single_en_n1",    {31'd0, uart_tx_en}, 32'd0);
    cyc();
    chk("single_en_n2",    {31'd0, uart_tx_en}, 32'd1);
    chk("single_data_n2",  {24'd0, uart_tx_data}, 32'h55);
    chk("single_level_n2", {28'd0, bus.level}, 32'd0);
    chk("single_busy_n2",  {31'd0, bus.busy}, 32'd1);
    cyc();
    chk("single_en_n3",    {31'd0, uart_tx_en}, 32'd0);
    begin
      int k = 0;
      while (uart_tx_busy && k < 50) begin
        cyc();
        k++;
      end
    end
    chk("single_uart_done", {31'd0, uart_tx_busy}, 32'd0);
    chk("single_busy_waitdone", {31'd0, bus.busy}, 32'd1);
    cyc();
    chk("single_busy_idle", {31'd0, bus.busy}, 32'd0);
    chk("single_data_hold", {24'd0, uart_tx_data}, 32'h55);

    // Burst of 10 bytes into depth 8 with a slow uart_tx
    hold = 100;
    base = n_tx;
    for (int i = 0; i < 10; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      cyc();
      if (i == 7) begin
        chk("burst_full_after8",  {31'd0, bus.full}, 32'd0);
        chk("burst_level_after8", {28'd0, bus.level}, 32'd7);
      end
      if (i == 8) begin
        chk("burst_full_after9",  {31'd0, bus.full}, 32'd1);
        chk("burst_level_after9", {28'd0, bus.level}, 32'd8);
        chk("burst_ovf_after9",   {31'd0, bus.overflow}, 32'd0);
      end
      if (i == 9) begin
        chk("burst_ovf_after10",   {31'd0, bus.overflow}, 32'd1);
        chk("burst_level_after10", {28'd0, bus.level}, 32'd8);
      end
    end
    bus.wr_en = 1'b0;
    wait_idle(3000);
    chk("burst_count", 32'(n_tx - base), 32'd9);
    for (int i = 0; i < 9; i++) begin
      chk("burst_order", {24'd0, tx_log[6'(base + i)]}, 32'(i));
    end
    chk("burst_ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // Flush clears overflow
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("flush_ovf_clear", {31'd0, bus.overflow}, 32'd0);

    // Start timeout: uart_tx never raises busy
    never_busy = 1'b1;
    base = n_tx;
    bus.wr_en = 1'b1; bus.wr_data = 8'hA1;
    cyc();
    bus.wr_data = 8'hA2;
    cyc();
    bus.wr_en = 1'b0;
    chk("tmo_en_first",   {31'd0, uart_tx_en}, 32'd1);
    chk("tmo_data_first", {24'd0, uart_tx_data}, 32'hA1);
    cyc();
    chk("tmo_en_ws0", {31'd0, uart_tx_en}, 32'd0);
    cyc();
    cyc();
    cyc();
    chk("tmo_en_back_idle", {31'd0, uart_tx_en}, 32'd0);
    chk("tmo_busy_pending", {31'd0, bus.busy}, 32'd1);
    cyc();
    chk("tmo_en_second",   {31'd0, uart_tx_en}, 32'd1);
    chk("tmo_data_second", {24'd0, uart_tx_data}, 32'hA2);
    cyc();
    cyc();
    cyc();
    cyc();
    chk("tmo_busy_done", {31'd0, bus.busy}, 32'd0);
    chk("tmo_count", 32'(n_tx - base), 32'd2);

    // Flush during WAIT_DONE with five bytes queued
    never_busy = 1'b0;
    hold = 20;
    base = n_tx;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'hB0 + i);
      cyc();
    end
    bus.wr_en = 1'b0;
    chk("fwd_level_before", {28'd0, bus.level}, 32'd5);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("fwd_level_after", {28'd0, bus.level}, 32'd0);
    chk("fwd_ovf_after",   {31'd0, bus.overflow}, 32'd0);
    chk("fwd_busy_inflight", {31'd0, bus.busy}, 32'd1);
    wait_idle(200);
    chk("fwd_count", 32'(n_tx - base), 32'd1);
    chk("fwd_byte",  {24'd0, tx_log[6'(base)]}, 32'hB0);

    // Flush and write in the same cycle with the FIFO full
    hold = 200;
    base = n_tx;
    for (int i = 0; i < 10; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'hC0 + i);
      cyc();
    end
    chk("ffw_full_before", {31'd0, bus.full}, 32'd1);
    chk("ffw_ovf_before",  {31'd0, bus.overflow}, 32'd1);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    cyc();
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    chk("ffw_level", {28'd0, bus.level}, 32'd0);
    chk("ffw_full",  {31'd0, bus.full}, 32'd0);
    chk("ffw_ovf",   {31'd0, bus.overflow}, 32'd0);
    wait_idle(400);
    chk("ffw_count", 32'(n_tx - base), 32'd1);
    chk("ffw_byte",  {24'd0, tx_log[6'(base)]}, 32'hC0);

    // Reset asserted mid-transfer in WAIT_DONE
    hold = 50;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'hD0 + i);
      cyc();
    end
    bus.wr_en = 1'b0;
    cyc();
    cyc();
    chk("rmid_level_before", {28'd0, bus.level}, 32'd2);
    chk("rmid_data_before",  {24'd0, uart_tx_data}, 32'hD0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_level", {28'd0, bus.level}, 32'd0);
    chk("rmid_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rmid_en",    {31'd0, uart_tx_en}, 32'd0);
    chk("rmid_data",  {24'd0, uart_tx_data}, 32'd0);
    chk("rmid_full",  {31'd0, bus.full}, 32'd0);
    chk("rmid_ovf",   {31'd0, bus.overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
